mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte/word memory port between up to NUM_REQ requesters (parser, matcher, action executor).
- Each requester drives the standard mem_ce/we/addr/width/data bundle and gets back a per-requester grant.
- Grants are round-robin and burst-locked: once granted, a requester owns the port for as long as it holds ce, so multi-cycle key/entry loads are never interleaved.
- A hold watchdog guarantees forward progress.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width.
- MAX_HOLD, 64, maximum consecutive cycles one requester may own the port.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (fixed by decision).
- req_ce_i  in  NUM_REQ  per-requester access request / burst hold.
- req_we_i  in  NUM_REQ  per-requester write enable.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_width_i  in  NUM_REQ*4  flattened access widths in bytes.
- req_data_i  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt_o  out  NUM_REQ  one-hot grant; at most one bit set.
- rdata_o  out  DATA_WIDTH  memory read data, broadcast to all requesters.
- mem_ce_o  out  1  memory chip enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_width_o  out  4  access width.
- mem_data_o  out  DATA_WIDTH  write data.
- mem_data_i  in  DATA_WIDTH  read data from memory.
- timeout_o  out  1  one-cycle pulse when the watchdog revokes a grant.
- timeout_id_o  out  3  index of the revoked requester; valid with timeout_o, held until the next timeout.

Behaviour:
- Reset (rst low, async):
  - gnt_o = 0, timeout_o = 0, timeout_id_o = 0.
  - state = IDLE, rr_ptr = 0, owner = 0, hold_cnt = 0.
  - Memory outputs are all 0 while in IDLE.
- Output forwarding is combinational:
  - In BUSY: mem_ce_o = req_ce_i[owner], and we/addr/width/data are taken from the owner's slice.
  - In IDLE: all memory outputs are 0.
  - mem_we_o is additionally gated by mem_ce_o.
  - rdata_o = mem_data_i at all times, no added latency; a requester samples it exactly as it would on a private port.
- IDLE:
  - If any req_ce_i bit is set, pick the first set index scanning rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - Next edge: owner = index, gnt_o = onehot(index), hold_cnt = 0, state = BUSY.
  - Grant latency from a request in IDLE is exactly 1 cycle.
  - The requester must keep ce high and addresses stable until it sees its gnt bit; a requester must not treat data as valid before grant.
- BUSY:
  - If req_ce_i[owner] = 0: next edge gnt_o = 0, rr_ptr = (owner+1) mod NUM_REQ, state = IDLE. This leaves one bubble cycle between bursts.
  - Else if hold_cnt == MAX_HOLD-1: forced release with the same updates, plus timeout_o = 1 for one cycle and timeout_id_o = owner.
  - Else hold_cnt increments (saturating width of clog2(MAX_HOLD)+1).
- Requests from non-owners during BUSY are ignored and wait; there is no preemption except the watchdog.
- Simultaneous release and re-request by the same requester: the rotated rr_ptr makes any other pending requester win the next arbitration. If none is pending, the same requester is re-granted after the bubble.
- Width rules:
  - rr_ptr and owner are clog2(NUM_REQ) bits; wrap from NUM_REQ-1 to 0.
  - Indices ≥ NUM_REQ are never produced.
- Reset mid-burst drops the grant and memory ce immediately (asynchronous); no partial-state recovery.

Test Plan:
- Single requester: req_ce_i=3'b010, addr 0x90, held 4 cycles then dropped. Required: gnt_o=3'b010 one cycle after the request; mem_addr_o=0x90 while granted; gnt_o=0 the cycle after ce drops; rr_ptr=2.
- Contention: all three requesters raise ce in the same cycle, each holding 3 cycles. Required: grants arrive in order 0, 1, 2, each 3 cycles long, with one idle cycle between; mem_ce_o is never asserted for a non-owner's slice.
- Fairness: requester 0 re-requests immediately after release while requester 2 is pending. Required: requester 2 is granted next, then requester 0.
- Watchdog (MAX_HOLD=8): requester 1 holds ce for 20 cycles. Required: gnt_o[1] falls after 8 granted cycles; timeout_o pulses once with timeout_id_o=1; requester 1 is re-granted after the bubble if still requesting and no other requester is pending.
- Reset mid-burst: rst driven low while requester 0 is granted with we=1. Required: gnt_o=0, mem_ce_o=0, mem_we_o=0 immediately (without waiting for a clock edge); after rst is released, arbitration restarts from rr_ptr=0.
- Read passthrough: while requester 2 is granted, the memory returns 0xA5. Required: rdata_o=0xA5 in the same cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin, burst-locked arbiter sharing one memory port between NUM_REQ requesters.
// A hold watchdog revokes any grant that outlives MAX_HOLD cycles.
module mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_ce_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*4-1:0]          req_width_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [3:0]                    mem_width_o,
  output logic [DATA_WIDTH-1:0]         mem_data_o,
  input  logic [DATA_WIDTH-1:0]         mem_data_i,
  output logic                          timeout_o,
  output logic [2:0]                    timeout_id_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic              state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic [HOLD_W-1:0] hold_cnt;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic              owner_ce;
  logic              hold_expired;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Scan downwards so the last hit written is the first set index from rr_ptr.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_ce_i[wrap_add(rr_ptr, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign next_ptr     = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
  assign owner_ce     = req_ce_i[owner];
  assign hold_expired = (hold_cnt == HOLD_LAST);

  always_comb begin
    gnt_o = '0;
    if (state == BUSY) gnt_o[owner] = 1'b1;
  end

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    if (state == BUSY) begin
      mem_ce_o    = owner_ce;
      mem_we_o    = owner_ce & req_we_i[owner];
      mem_addr_o  = req_addr_i[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_width_o = req_width_i[int'(owner)*4 +: 4];
      mem_data_o  = req_data_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rdata_o = mem_data_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      hold_cnt     <= '0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
    end else begin
      timeout_o <= 1'b0;
      if (state == IDLE) begin
        if (pick_valid) begin
          owner    <= pick_idx;
          hold_cnt <= '0;
          state    <= BUSY;
        end
      end else begin
        if (!owner_ce || hold_expired) begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
          // Still requesting here means the watchdog, not the owner, ended the burst.
          if (owner_ce) begin
            timeout_o    <= 1'b1;
            timeout_id_o <= 3'(owner);
          end
        end else if (hold_cnt != '1) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a cycle-level reference model predicts
// grant/release/timeout events into a queue that an independent monitor consumes.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 8;

  localparam logic [1:0] EV_GRANT = 2'd0;
  localparam logic [1:0] EV_REL   = 2'd1;
  localparam logic [1:0] EV_TO    = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  id;
    int unsigned cyc;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_ce, req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*4-1:0]    req_width;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      gnt_o;
  logic [DW-1:0]     rdata_o;
  logic              mem_ce_o, mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [3:0]        mem_width_o;
  logic [DW-1:0]     mem_data_o;
  logic [DW-1:0]     mem_data_i;
  logic              timeout_o;
  logic [2:0]        timeout_id_o;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_width_i(req_width), .req_data_i(req_data),
    .gnt_o(gnt_o), .rdata_o(rdata_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .timeout_o(timeout_o), .timeout_id_o(timeout_id_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  ev_t         exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who owns the port, where the next scan starts, how long the owner has held it.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_cand;
  bit m_found;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      m_found = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_cand = (m_ptr + i) % N;
        if (!m_found && req_ce[m_cand]) begin
          m_found = 1'b1;
          m_owner = m_cand;
          m_held  = 0;
          exp_q.push_back('{EV_GRANT, 3'(m_cand), cyc});
        end
      end
    end else if (!req_ce[m_owner]) begin
      exp_q.push_back('{EV_REL, 3'(m_owner), cyc});
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (m_held + 1 >= MH) begin
      exp_q.push_back('{EV_REL, 3'(m_owner), cyc});
      exp_q.push_back('{EV_TO, 3'(m_owner), cyc});
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_held = m_held + 1;
    end
  end

  // Monitor: turns DUT output changes into events and matches them against the queue.
  logic [N-1:0] prev_gnt = '0;
  int           mon_owner = -1;
  logic [2:0]   mon_tid = '0;

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic match_event(input string name, input logic [1:0] kind, input logic [2:0] id);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, {kind, id, cyc}, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check(name, {kind, id, cyc}, {e.kind, e.id, e.cyc});
      case (e.kind)
        EV_GRANT: mon_owner = int'(e.id);
        EV_REL:   mon_owner = -1;
        default:  mon_tid = e.id;
      endcase
    end
  endtask

  logic exp_ce;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_gnt  = '0;
      mon_owner = -1;
      mon_tid   = '0;
    end else begin
      check("gnt_onehot", 64'($countones(gnt_o) <= 1), 64'd1);
      if (gnt_o != prev_gnt) begin
        if (prev_gnt != '0) match_event("release", EV_REL, 3'(oh_idx(prev_gnt)));
        if (gnt_o != '0)    match_event("grant", EV_GRANT, 3'(oh_idx(gnt_o)));
      end
      if (timeout_o) match_event("timeout", EV_TO, timeout_id_o);
      prev_gnt = gnt_o;
      check("timeout_id_hold", 64'(timeout_id_o), 64'(mon_tid));
      exp_ce = (mon_owner >= 0) ? req_ce[mon_owner] : 1'b0;
      check("mem_ce", 64'(mem_ce_o), 64'(exp_ce));
      check("mem_we", 64'(mem_we_o), 64'(exp_ce & ((mon_owner >= 0) ? req_we[mon_owner] : 1'b0)));
      if (mon_owner >= 0) begin
        check("mem_addr", 64'(mem_addr_o), 64'(req_addr[mon_owner*AW +: AW]));
        check("mem_width", 64'(mem_width_o), 64'(req_width[mon_owner*4 +: 4]));
        check("mem_data", 64'(mem_data_o), 64'(req_data[mon_owner*DW +: DW]));
      end else begin
        check("mem_idle", 64'({mem_addr_o, mem_width_o} | 64'(mem_data_o)), 64'd0);
      end
      check("rdata", 64'(rdata_o), 64'(mem_data_i));
    end
  end

  // Requester agents: hold ce until granted, stay for blen granted cycles, optionally re-request.
  int blen[N], used[N], reps[N];
  bit pend[N];
  bit rand_rdata = 1'b1;

  task automatic start_burst(input int k, input int len, input int rep, input logic we,
                             input logic [AW-1:0] addr, input logic [3:0] width);
    req_ce[k] = 1'b1;
    req_we[k] = we;
    req_addr[k*AW +: AW] = addr;
    req_width[k*4 +: 4] = width;
    req_data[k*DW +: DW] = $urandom;
    blen[k] = len;
    used[k] = 0;
    reps[k] = rep;
    pend[k] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdata) mem_data_i = $urandom;
    for (int k = 0; k < N; k++) begin
      if (pend[k]) begin
        pend[k]   = 1'b0;
        req_ce[k] = 1'b1;
        used[k]   = 0;
      end else if (req_ce[k] && gnt_o[k]) begin
        if (used[k] >= blen[k]) begin
          req_ce[k] = 1'b0;
          if (reps[k] > 0) begin
            reps[k]--;
            pend[k] = 1'b1;
          end
        end else begin
          used[k]++;
          req_addr[k*AW +: AW] = $urandom;
          req_data[k*DW +: DW] = $urandom;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  bit seen;

  initial begin
    rst = 1'b0;
    req_ce = '0; req_we = '0; req_addr = '0; req_width = '0; req_data = '0;
    mem_data_i = '0;
    for (int k = 0; k < N; k++) begin
      blen[k] = 0; used[k] = 0; reps[k] = 0; pend[k] = 1'b0;
    end
    run(3);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_timeout", 64'({timeout_o, timeout_id_o}), 64'd0);
    check("rst_mem_ce", 64'({mem_ce_o, mem_we_o}), 64'd0);
    rst = 1'b1;

    // Single requester: grant one cycle after the request, address forwarded.
    run(2);
    start_burst(1, 4, 0, 1'b0, 32'h90, 4'd4);
    tick();
    check("single_gnt", 64'(gnt_o), 64'b010);
    check("single_addr", 64'(mem_addr_o), 64'h90);
    run(12);

    // Contention: grants in order 0,1,2 with bubbles.
    start_burst(0, 3, 0, 1'b1, 32'h100, 4'd4);
    start_burst(1, 3, 0, 1'b0, 32'h200, 4'd2);
    start_burst(2, 3, 0, 1'b1, 32'h300, 4'd1);
    run(20);

    // Fairness: 0 re-requests right after release while 2 waits.
    start_burst(0, 3, 1, 1'b0, 32'h400, 4'd4);
    run(2);
    start_burst(2, 2, 0, 1'b0, 32'h500, 4'd4);
    run(24);

    // Watchdog: 1 holds ce for 20 cycles.
    start_burst(1, 20, 0, 1'b1, 32'h600, 4'd4);
    run(40);

    // Reset mid-burst with a nonzero rotation pointer beforehand.
    start_burst(1, 2, 0, 1'b0, 32'h700, 4'd4);
    run(6);
    start_burst(0, 10, 0, 1'b1, 32'h800, 4'd4);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = gnt_o[0];
    end
    check("rst_wait_gnt0", 64'(seen), 64'd1);
    check("pre_rst_we", 64'(mem_we_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_gnt", 64'(gnt_o), 64'd0);
    check("async_rst_ce", 64'(mem_ce_o), 64'd0);
    check("async_rst_we", 64'(mem_we_o), 64'd0);
    run(2);
    start_burst(1, 2, 0, 1'b0, 32'h900, 4'd4);
    start_burst(2, 2, 0, 1'b0, 32'hA00, 4'd4);
    rst = 1'b1;
    tick();
    check("post_rst_gnt0", 64'(gnt_o), 64'b001);
    run(40);

    // Read passthrough while requester 2 is granted.
    rand_rdata = 1'b0;
    start_burst(2, 4, 0, 1'b0, 32'hB00, 4'd4);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = gnt_o[2];
    end
    check("pass_wait_gnt2", 64'(seen), 64'd1);
    mem_data_i = 32'hA5;
    #1;
    check("pass_rdata", 64'(rdata_o), 64'hA5);
    run(10);
    rand_rdata = 1'b1;

    // Randomized traffic, including bursts that trip the watchdog.
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_ce[k] && !pend[k] && ($urandom_range(0, 5) == 0))
          start_burst(k, $urandom_range(0, 12), $urandom_range(0, 1), 1'($urandom),
                      $urandom, 4'($urandom_range(1, 4)));
      end
      tick();
    end
    run(200);
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
